// File: rtl/fp_mant_normalizer_pkg.sv
// Shared types and defaults for the FP add/sub mantissa normalizer.
package fp_pkg;

    localparam int MAN_W_DEF = 7;
    localparam int EXP_W_DEF = 8;

    localparam logic [EXP_W_DEF-1:0] EXP_ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_e;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero;
        logic inexact;
    } fp_flags_t;

endpackage

// File: rtl/fp_exp_incdec.sv
// Ripple +/-1 on an unsigned exponent, built as a chain of 1-bit full adders.
module fp_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module fp_exp_incdec #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic         up,
    output logic [W-1:0] y
);
    // up: a + 0 + cin(1); down: a + all-ones + cin(0), i.e. a - 1
    logic [W-1:0] c;

    assign c[0] = up;

    for (genvar i = 0; i < W - 1; i++) begin : g_fa
        fp_fa u_fa (
            .a  (a[i]),
            .b  (~up),
            .ci (c[i]),
            .s  (y[i]),
            .co (c[i+1])
        );
    end

    assign y[W-1] = a[W-1] ^ ~up ^ c[W-1];

endmodule

// File: rtl/fp_mant_normalizer.sv
// Serial mantissa normalizer: one shift per cycle, one operation in flight.
module fp_mant_normalizer import fp_pkg::*; #(
    parameter int MAN_W = MAN_W_DEF,
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W:0]   in_raw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_mant,
    output logic [3:0]       out_flags
);

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    norm_state_e      state;
    logic             sign_q;
    logic [EXP_W-1:0] exp_q;
    logic [MAN_W:0]   raw_q;
    logic             special_q;
    fp_flags_t        flags_q;
    logic [EXP_W-1:0] exp_nxt;

    // Direction follows the carry: carry set means the only move is right/up.
    fp_exp_incdec #(.W(EXP_W)) u_incdec (
        .a  (exp_q),
        .up (raw_q[MAN_W]),
        .y  (exp_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            raw_q     <= '0;
            special_q <= 1'b0;
            flags_q   <= '0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_mant  <= '0;
            out_flags <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q    <= in_sign;
                        exp_q     <= in_exp;
                        raw_q     <= in_raw;
                        special_q <= (in_exp == EXP_MAX);
                        flags_q   <= '0;
                        in_ready  <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (special_q) begin
                        state <= DONE;
                    end else if (raw_q == '0) begin
                        exp_q        <= '0;
                        flags_q.zero <= 1'b1;
                        state        <= DONE;
                    end else if (raw_q[MAN_W]) begin
                        raw_q           <= {1'b0, raw_q[MAN_W:1]};
                        exp_q           <= exp_nxt;
                        flags_q.inexact <= flags_q.inexact | raw_q[0];
                        // Saturate: reaching all-ones is overflow, never wrap.
                        if (exp_nxt == EXP_MAX) begin
                            raw_q       <= '0;
                            flags_q.ovf <= 1'b1;
                            state       <= DONE;
                        end
                    end else if (raw_q[MAN_W-1]) begin
                        state <= DONE;
                    end else if (exp_q <= EXP_ONE) begin
                        exp_q        <= '0;
                        raw_q        <= '0;
                        flags_q.unf  <= 1'b1;
                        flags_q.zero <= 1'b1;
                        state        <= DONE;
                    end else begin
                        raw_q <= raw_q << 1;
                        exp_q <= exp_nxt;
                    end
                end
                DONE: begin
                    // First DONE cycle loads the output registers, then hold.
                    if (!out_valid) begin
                        out_sign  <= sign_q;
                        out_exp   <= exp_q;
                        out_mant  <= raw_q[MAN_W-1:0];
                        out_flags <= flags_q;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
